uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver, the successor to the single-byte receiver in the peripheral subsystem. It runs on the system clock with a counter-based bit timer and samples each bit at mid-bit, so no divided clock is generated. It detects false starts and framing errors and buffers received words in a small FIFO with a valid/ready output handshake. It sits between the external RX pin and the CPU-side MMIO register block.

Parameters:
CLK_DIV, 208, system clocks per bit period (208 at 12 MHz gives 57600 bps); must be >= 8
DATA_BITS, 8, data bits per frame (5..9), LSB first
FIFO_DEPTH, 4, received-word buffer entries (power of two, >= 2)
SYNC_STAGES, 2, synchroniser flops on uartRxPin (>= 2)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
uartRxPin  input  1  asynchronous serial line, idle high
data  output  DATA_BITS  word at FIFO head; valid only while valid=1
valid  output  1  FIFO non-empty
ready  input  1  consumer accepts the head word when valid&&ready
frameError  output  1  one-cycle pulse: stop bit sampled low
parityError  output  1  one-cycle pulse: parity mismatch (tied 0 without the macro)
overrun  output  1  one-cycle pulse: completed word dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, reset=0): state IDLE, synchroniser flops preset to 1, bit timer 0, FIFO empty.
- Output values during reset: data=0, valid=0, frameError=0, parityError=0, overrun=0.
- A frame in progress when reset asserts is discarded.
- Synchroniser: the FSM sees rxs, which is uartRxPin delayed SYNC_STAGES clocks.
- Bit timer: counts 0..CLK_DIV-1 and wraps; it is cleared whenever the FSM enters START.
- IDLE: rxs=0 -> START, timer cleared.
- START: at timer=CLK_DIV/2-1, sample rxs.
  - 1 -> false start; return to IDLE, no error flagged.
  - 0 -> DATA; timer cleared, bit index 0.
- DATA: sample rxs at each timer=CLK_DIV-1 and shift it in at the top (LSB first).
  - After DATA_BITS samples -> PARITY if the macro is enabled, otherwise STOP.
- PARITY: sample one bit after another CLK_DIV clocks -> STOP.
- STOP: sample after another CLK_DIV clocks.
  - rxs=1: push the word, go to IDLE.
  - rxs=0: frameError pulses for one cycle, word discarded, go to BREAK.
- BREAK: wait for rxs=1, then go to IDLE. A held-low line produces exactly one frameError.
- Push timing: the word is written in the cycle of the stop sample and valid=1 on the next clock edge.
  - Total latency from the stop-bit midpoint on the pin is SYNC_STAGES+1 clocks.
- FIFO:
  - Pop when valid&&ready.
  - data is the head entry, registered, and stable while valid&&!ready.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Full = pointers differ only in the MSB.
- Simultaneous push and pop:
  - Both take effect.
  - When the FIFO is full, the push is accepted because the pop frees an entry. No overrun.
  - When the FIFO is empty, the push is stored and valid rises. No bypass: data is never presented in the same cycle it is pushed.
- Push while full without a pop: the word is dropped, overrun pulses, and FIFO contents are unchanged.
- Error pulses are mutually exclusive per frame. Priority is frameError > parityError.
  - A word with a parity or framing error is never pushed.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - PARITY state present; the frame is start + DATA_BITS + parity + stop.
  - Parity is even: the XOR of the data bits and the parity bit must be 0.
  - On mismatch, parityError pulses for one cycle in the stop-sample cycle (only if the stop bit is 1) and the word is dropped.
- Undefined: PARITY state absent, parityError tied to 0, frame is start + DATA_BITS + stop.

Test Plan:
- CLK_DIV=16, ready=1, send 0x55 8N1 -> valid for exactly 1 cycle with data=0x55, SYNC_STAGES+1 clocks after the stop midpoint; no error pulses.
- Glitch: line low for 4 clocks, then high (CLK_DIV=16) -> FSM returns to IDLE; valid, frameError and overrun stay 0. A following 0xA3 frame is received correctly.
- 0x3C frame with the stop bit held low, line released 3 bit-times later -> one frameError pulse, valid stays 0. A next frame 0x81 is received.
- ready=0, send FIFO_DEPTH+1 frames 0x01..0x05 (depth 4) -> overrun pulses once on the 5th. Raising ready pops 0x01,0x02,0x03,0x04 in order, then valid=0.
- FIFO full and ready=1 exactly in the stop-sample cycle of a 6th frame 0x06 -> no overrun; the FIFO ends with 0x02..0x04,0x06.
- UART_RX_PARITY_EN defined: 0x07 with parity 1 -> data=0x07. 0x07 with parity 0 -> parityError pulse, no push. Apply reset mid-data-bit -> all outputs 0, and the next frame is received cleanly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchronised RX line, mid-bit sampling from a counter bit timer,
// FIFO output buffer with valid/ready. Define UART_RX_PARITY_EN for even parity.
module uart_rx_fifo #(
    parameter int CLK_DIV     = 208,
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 uartRxPin,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frameError,
    output logic                 parityError,
    output logic                 overrun
);
    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] TMAX  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] THALF = TW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [TW-1:0]          timer_q, timer_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   stop_smp, par_bad, push_req;

    // Preset to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], uartRxPin};
    end
    assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) par_q <= 1'b0;
        else        par_q <= par_d;
    end
    assign par_bad = ^{shift_q, par_q};
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = (timer_q == TMAX) ? '0 : timer_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        stop_smp = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: if (!rxs) begin
                state_d = START;
                timer_d = '0;
            end
            START: if (timer_q == THALF) begin
                if (rxs) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    timer_d = '0;
                    bit_d   = '0;
                end
            end
            DATA: if (timer_q == TMAX) begin
                shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                bit_d   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                if (bit_q == BLAST) state_d = PARITY;
`else
                if (bit_q == BLAST) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (timer_q == TMAX) begin
                par_d   = rxs;
                state_d = STOP;
            end
`endif
            STOP: if (timer_q == TMAX) begin
                stop_smp = 1'b1;
                state_d  = rxs ? IDLE : BRK;
            end
            BRK: if (rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Framing error wins over parity; only clean words reach the FIFO.
    assign frameError  = stop_smp && !rxs;
    assign parityError = stop_smp && rxs && par_bad;
    assign push_req    = stop_smp && rxs && !par_bad;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wptr_q, rptr_q, rptr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 full, pop, do_push;

    assign valid   = (wptr_q != rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop     = valid && ready;
    assign do_push = push_req && (!full || pop);
    assign overrun = push_req && full && !pop;
    assign rptr_d  = rptr_q + {{AW{1'b0}}, pop};

    // Head register tracks the entry that will be at the read pointer next cycle.
    always_comb begin
        data_d = mem_q[rptr_d[AW-1:0]];
        if (do_push && (rptr_d[AW-1:0] == wptr_q[AW-1:0])) data_d = shift_q;
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= shift_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            data_q <= '0;
        end else begin
            wptr_q <= wptr_q + {{AW{1'b0}}, do_push};
            rptr_q <= rptr_d;
            data_q <= data_d;
        end
    end
    assign data = data_q;

endmodule
